// File: rtl/fpu_norm_pipe_if.sv
// Valid/ready channel pair around the FPU normaliser: adder result in, packed result and flags out.
// The slave modport is the normaliser; the master modport is whoever feeds and drains it.
interface fpu_norm_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int IN_W  = 1 + EXP_W + MAN_W + 5;
    localparam int OUT_W = 1 + EXP_W + MAN_W;

    logic             valid_i;
    logic             ready_o;
    logic [IN_W-1:0]  add_i;
    logic             valid_o;
    logic             ready_i;
    logic [OUT_W-1:0] norm_o;
    logic             of_o;
    logic             uf_o;

    modport master (
        output valid_i, add_i, ready_i,
        input  ready_o, valid_o, norm_o, of_o, uf_o
    );

    modport slave (
        input  valid_i, add_i, ready_i,
        output ready_o, valid_o, norm_o, of_o, uf_o
    );
endinterface

// File: rtl/fpu_norm_pipe.sv
// Two-stage normaliser/rounder for the FPU add/sub path: stage 1 counts leading zeros and
// adjusts the exponent, stage 2 shifts, rounds to nearest-even, flushes to zero or saturates to inf.
module fpu_norm_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic            clk_i,
    input logic            rst_ni,
    fpu_norm_pipe_if.slave bus
);
    localparam int MW   = MAN_W + 5;       // {carry, hidden, frac, G, R, S}
    localparam int NW   = MAN_W + 4;       // everything below the carry bit
    localparam int EW2  = EXP_W + 2;
    localparam int IN_W = 1 + EXP_W + MW;
    localparam int LZ_W = $clog2(MW);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        K_NORMAL,
        K_SPECIAL,
        K_ZERO
    } kind_e;

    function automatic logic [LZ_W-1:0] lead_zeros(input logic [NW-1:0] v);
        lead_zeros = '0;
        for (int i = 0; i < NW; i++) begin
            if (v[i]) lead_zeros = LZ_W'(NW - 1 - i);
        end
    endfunction

    logic adv1, adv2;
    logic v1, v2;

    assign adv2        = !v2 || bus.ready_i;
    assign adv1        = !v1 || adv2;
    assign bus.ready_o = adv1;

    // ---------------- stage 1: classify, count leading zeros, adjust exponent
    logic                  sign_in;
    logic [EXP_W-1:0]      exp_in;
    logic [MW-1:0]         m_in;
    kind_e                 kind_d;
    logic [LZ_W-1:0]       lz_d;
    logic signed [EW2-1:0] exp_d;

    assign sign_in = bus.add_i[IN_W-1];
    assign exp_in  = bus.add_i[IN_W-2 -: EXP_W];
    assign m_in    = bus.add_i[MW-1:0];

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        kind_d = K_NORMAL;
        lz_d   = lead_zeros(m_in[NW-1:0]);
        exp_d  = EW2'(exp_in);
        if (exp_in == '1) begin
            kind_d = K_SPECIAL;
        end else if (m_in == '0) begin
            kind_d = K_ZERO;
        end else if (m_in[MW-1]) begin
            exp_d = EW2'(exp_in) + EW2'(1);
        end else if (!m_in[NW-1]) begin
            exp_d = EW2'(exp_in) - EW2'(lz_d);
        end
    end

    kind_e                 kind1;
    logic                  sign1;
    logic signed [EW2-1:0] exp1;
    logic [MW-1:0]         m1;
    logic [LZ_W-1:0]       lz1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1    <= 1'b0;
            kind1 <= K_NORMAL;
            sign1 <= 1'b0;
            exp1  <= '0;
            m1    <= '0;
            lz1   <= '0;
        end else if (adv1) begin
            v1 <= bus.valid_i;
            if (bus.valid_i) begin
                kind1 <= kind_d;
                sign1 <= sign_in;
                exp1  <= exp_d;
                m1    <= m_in;
                lz1   <= lz_d;
            end
        end
    end

    // ---------------- stage 2: shift, round, pack
    logic [NW-2:0]         n_lo;        // {frac, G, R, S} after normalisation, hidden bit dropped
    logic [MAN_W-1:0]      frac_n;
    logic                  round_up;
    logic [MAN_W:0]        frac_sum;
    logic signed [EW2-1:0] exp_f;
    logic [EXP_W+MAN_W:0]  norm_d;
    logic                  of_d, uf_d;

    // A right shift folds the dropped R and S together so stickiness survives.
    assign n_lo     = m1[MW-1] ? {m1[NW-1:2], m1[1] | m1[0]} : m1[NW-2:0] << lz1;
    assign frac_n   = n_lo[NW-2:3];
    assign round_up = n_lo[2] && (n_lo[1] || n_lo[0] || frac_n[0]);
    assign frac_sum = {1'b0, frac_n} + (MAN_W + 1)'(round_up);
    assign exp_f    = exp1 + EW2'(frac_sum[MAN_W]);

    always_comb begin
        norm_d = {sign1, exp_f[EXP_W-1:0], frac_sum[MAN_W-1:0]};
        of_d   = 1'b0;
        uf_d   = 1'b0;
        case (kind1)
            K_SPECIAL: norm_d = {sign1, {EXP_W{1'b1}}, m1[NW-2:3]};
            K_ZERO:    norm_d = {sign1, {(EXP_W + MAN_W){1'b0}}};
            default: begin
                if (exp1 <= EXP_ZERO) begin
                    norm_d = {sign1, {(EXP_W + MAN_W){1'b0}}};
                    uf_d   = 1'b1;
                end else if (exp_f >= EXP_MAX) begin
                    norm_d = {sign1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    of_d   = 1'b1;
                end
            end
        endcase
    end

    logic [EXP_W+MAN_W:0] norm_q;
    logic                 of_q, uf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v2     <= 1'b0;
            norm_q <= '0;
            of_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                norm_q <= norm_d;
                of_q   <= of_d;
                uf_q   <= uf_d;
            end
        end
    end

    assign bus.valid_o = v2;
    assign bus.norm_o  = norm_q;
    assign bus.of_o    = of_q;
    assign bus.uf_o    = uf_q;
endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Bench for fpu_norm_pipe: directed vectors with hand-derived results, a stall/release sequence,
// mid-stream reset, and randomized traffic checked against an arithmetic reference model.
module tb_fpu_norm_pipe;
    typedef struct {
        logic [31:0] norm;
        logic        of_f;
        logic        uf_f;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic acc;
    int   popped;
    res_t pend;
    res_t exp_q[$];

    fpu_norm_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_norm_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t rr(input logic [31:0] norm, input logic of_f, input logic uf_f);
        res_t r;
        r.norm = norm;
        r.of_f = of_f;
        r.uf_f = uf_f;
        return r;
    endfunction

    function automatic logic [36:0] mk(input logic s, input logic [7:0] e, input logic c,
                                       input logic h, input logic [22:0] f, input logic [2:0] grs);
        return {s, e, c, h, f, grs};
    endfunction

    // Reference: locate the MSB, rescale it to the hidden position, then round the integer.
    function automatic res_t model(input logic [36:0] a);
        res_t   r;
        longint m, n, kept, rem;
        int     e, p;
        logic   s;
        s = a[36];
        m = longint'(a[27:0]);
        r = rr(32'h0, 1'b0, 1'b0);
        if (a[35:28] == 8'hFF) begin
            r.norm = {s, 8'hFF, a[25:3]};
        end else if (m == 0) begin
            r.norm = {s, 31'b0};
        end else begin
            p = 0;
            for (int i = 0; i < 28; i++) if (m[i]) p = i;
            e = int'(a[35:28]) + p - 26;
            if (p == 27) n = (m >> 1) | (m & 1);
            else         n = m << (26 - p);
            if (e <= 0) begin
                r.norm = {s, 31'b0};
                r.uf_f = 1'b1;
            end else begin
                kept = n >> 3;
                rem  = n & 7;
                if (rem > 4 || (rem == 4 && kept[0])) kept++;
                if (kept >= (longint'(1) << 24)) begin
                    kept = kept >> 1;
                    e++;
                end
                if (e >= 255) begin
                    r.norm = {s, 8'hFF, 23'b0};
                    r.of_f = 1'b1;
                end else begin
                    r.norm = {s, 8'(e), kept[22:0]};
                end
            end
        end
        return r;
    endfunction

    function automatic logic [36:0] rand_vec();
        logic [27:0] m;
        logic [7:0]  e;
        m = 28'($urandom);
        m = m >> $urandom_range(0, 28);
        case ($urandom_range(0, 4))
            0:       e = 8'($urandom_range(0, 30));
            1:       e = 8'($urandom_range(225, 255));
            2:       e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, m};
    endfunction

    // One clock: sample handshakes on the falling edge, then return just after the rising edge.
    task automatic step();
        res_t r;
        @(negedge clk);
        acc    = bus.valid_i && bus.ready_o;
        popped = 0;
        if (bus.valid_o && bus.ready_i) begin
            popped = 1;
            tests++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("FAIL spurious_out: observed %0h expected none", bus.norm_o);
            end
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("out", {bus.norm_o, bus.of_o, bus.uf_o}, {r.norm, r.of_f, r.uf_f});
            end
        end
        if (acc) exp_q.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [36:0] a, input res_t r);
        bus.add_i   = a;
        bus.valid_i = 1'b1;
        pend        = r;
        acc         = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (acc) break;
        end
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic drain();
        bus.valid_i = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    logic [36:0] v1, v2, v3, a;

    initial begin
        bus.valid_i = 1'b0;
        bus.add_i   = '0;
        bus.ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid_o", bus.valid_o, 1'b0);
        check("rst_outputs", {bus.norm_o, bus.of_o, bus.uf_o}, 34'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready_o", bus.ready_o, 1'b1);

        v1 = mk(1'b0, 8'h7F, 1'b1, 1'b0, 23'h0, 3'b000);
        v2 = mk(1'b0, 8'h85, 1'b0, 1'b0, 23'h200000, 3'b000);
        v3 = mk(1'b0, 8'h7F, 1'b0, 1'b1, 23'h7FFFFF, 3'b100);

        // Directed vectors, streamed back to back.
        send(v1, rr(32'h40000000, 1'b0, 1'b0));
        send(v2, rr(32'h41800000, 1'b0, 1'b0));
        send(v3, rr(32'h40000000, 1'b0, 1'b0));
        send(mk(1'b0, 8'h7F, 1'b0, 1'b1, 23'h000002, 3'b100), rr(32'h3F800002, 1'b0, 1'b0));
        send(mk(1'b0, 8'hFE, 1'b1, 1'b0, 23'h0, 3'b000), rr(32'h7F800000, 1'b1, 1'b0));
        send(mk(1'b1, 8'hFE, 1'b1, 1'b0, 23'h0, 3'b000), rr(32'hFF800000, 1'b1, 1'b0));
        send(mk(1'b1, 8'h02, 1'b0, 1'b0, 23'h040000, 3'b000), rr(32'h80000000, 1'b0, 1'b1));
        send(mk(1'b0, 8'h40, 1'b0, 1'b0, 23'h0, 3'b000), rr(32'h00000000, 1'b0, 1'b0));
        send(mk(1'b1, 8'hFF, 1'b0, 1'b1, 23'h123456, 3'b111), rr(32'hFF923456, 1'b0, 1'b0));
        send(mk(1'b0, 8'h00, 1'b0, 1'b1, 23'h0, 3'b000), rr(32'h00000000, 1'b0, 1'b1));
        drain();

        // Stall: two held, third waits at the input.
        bus.ready_i = 1'b0;
        send(v1, rr(32'h40000000, 1'b0, 1'b0));
        send(v2, rr(32'h41800000, 1'b0, 1'b0));
        bus.add_i   = v3;
        bus.valid_i = 1'b1;
        pend        = rr(32'h40000000, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_ready_o", bus.ready_o, 1'b0);
            check("stall_hold", {bus.valid_o, bus.norm_o, bus.of_o, bus.uf_o},
                  {1'b1, 32'h40000000, 2'b00});
        end
        bus.ready_i = 1'b1;
        step();
        check("release_accept_v3", acc, 1'b1);
        check("release_pop1", popped, 1);
        bus.valid_i = 1'b0;
        step();
        check("release_pop2", popped, 1);
        step();
        check("release_pop3", popped, 1);
        check("release_q_empty", exp_q.size(), 0);

        // Reset with the pipeline full.
        for (int k = 0; k < 2; k++) begin
            a = rand_vec();
            send(a, model(a));
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid_o", bus.valid_o, 1'b0);
        check("midrst_ready_o", bus.ready_o, 1'b1);
        check("midrst_outputs", {bus.norm_o, bus.of_o, bus.uf_o}, 34'h0);
        exp_q.delete();
        bus.valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("post_rst_idle", bus.valid_o, 1'b0);
        end

        // Randomized traffic with random backpressure.
        acc = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!bus.valid_i || acc) begin
                if ($urandom_range(0, 3) != 0) begin
                    a           = rand_vec();
                    bus.add_i   = a;
                    pend        = model(a);
                    bus.valid_i = 1'b1;
                end else begin
                    bus.valid_i = 1'b0;
                end
            end
            bus.ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.ready_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
